// File: rtl/prog_clk_divider.sv
// -----------------------------------------------------------------------------
// prog_clk_divider
//
// Runtime-programmable clock divider and tick generator. A divisor N gives a
// registered divided_clk with period N clk cycles: ceil(N/2) cycles high, then
// floor(N/2) cycles low. Odd and even N are both supported. A new divisor is
// held as "pending" and only takes effect at a period boundary. This keeps the
// output free of glitches, runt pulses and mixed-length periods.
//
// Optional feature (compile-time macro CLK_DIV_PERIOD_CNT_EN):
//   When defined, adds output period_cnt, a 16-bit wrapping count of the
//   periods started. It steps together with every tick, resets to 0 and is not
//   cleared on entry to IDLE. When undefined, the port and counter are absent.
//
// Parameters
//   CNT_W        width of the divisor and of the phase counter
//   DEFAULT_DIV  divisor active after reset (>= 2, < 2**CNT_W)
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   en           run request; a new period only starts while en is high
//   div_wr       one-cycle write strobe for div_in
//   div_in       requested divisor N
//   divided_clk  divided output (registered)
//   tick         one-cycle pulse in the first cycle of every period
//   div_busy     a written divisor is pending and not yet active
//   div_err      one-cycle pulse after a rejected write (div_in < 2)
//   state_dbg    current FSM state (0 = IDLE, 1 = HIGH, 2 = LOW), for debug
//   period_cnt   count of started periods (only with CLK_DIV_PERIOD_CNT_EN)
//
// Handshake: div_wr is a plain strobe and has no ready. Any write with
// div_in >= 2 is accepted on the edge where it is sampled. div_busy then stays
// high until a period start consumes the pending value. A later write
// overwrites the pending value.
// -----------------------------------------------------------------------------
module prog_clk_divider #(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_wr,
    input  logic [CNT_W-1:0] div_in,
    output logic             divided_clk,
    output logic             tick,
    output logic             div_busy,
    output logic             div_err,
    output logic [1:0]       state_dbg
`ifdef CLK_DIV_PERIOD_CNT_EN
    ,
    output logic [15:0]      period_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    // Registered state
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dclk_q;
    logic             tick_q;
    logic [CNT_W-1:0] active_q;
    logic [CNT_W-1:0] pend_q;
    logic             pvalid_q;
    logic             err_q;
    // en sampled on the previous edge. Leaving IDLE uses this copy, so a
    // request seen at edge k starts the first period at edge k+1.
    logic             en_q;

    // Next-state values
    state_t           state_d;
    logic [CNT_W-1:0] cnt_d;
    logic             dclk_d;
    logic             tick_d;
    logic [CNT_W-1:0] active_d;
    logic [CNT_W-1:0] pend_d;
    logic             pvalid_d;
    logic             err_d;
    logic             start;
    logic             wr_ok;

    // Phase lengths derived from the active divisor: HI = N - N/2, LO = N/2.
    // Both are at least 1 because N >= 2 is enforced on every write.
    logic [CNT_W-1:0] lo_len;
    logic [CNT_W-1:0] hi_len;
    logic [CNT_W-1:0] hi_last;
    logic [CNT_W-1:0] lo_last;

    assign lo_len  = active_q >> 1;
    assign hi_len  = active_q - lo_len;
    assign hi_last = hi_len - ONE;
    assign lo_last = lo_len - ONE;

`ifdef CLK_DIV_PERIOD_CNT_EN
    logic [15:0] pcnt_q;
    logic [15:0] pcnt_d;
`endif

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dclk_d   = dclk_q;
        tick_d   = 1'b0;
        active_d = active_q;
        pend_d   = pend_q;
        pvalid_d = pvalid_q;
        err_d    = 1'b0;
        start    = 1'b0;
        wr_ok    = 1'b0;

        case (state_q)
            IDLE: begin
                dclk_d = 1'b0;
                if (en_q) begin
                    start = 1'b1;
                end
            end

            HIGH: begin
                if (cnt_q == hi_last) begin
                    state_d = LOW;
                    dclk_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end

            LOW: begin
                // The last LOW cycle is the period boundary. Only here can a
                // running divider stop or start its next period, so en changes
                // mid-period never shorten a pulse.
                if (cnt_q == lo_last) begin
                    if (en) begin
                        start = 1'b1;
                    end else begin
                        state_d = IDLE;
                        dclk_d  = 1'b0;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end

            default: begin
                state_d = IDLE;
                dclk_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase

        // Period start: the pending divisor (if any) is adopted on the same
        // edge. The first HIGH phase therefore already uses the new N.
        if (start) begin
            state_d = HIGH;
            dclk_d  = 1'b1;
            tick_d  = 1'b1;
            cnt_d   = '0;
            if (pvalid_q) begin
                active_d = pend_q;
                pvalid_d = 1'b0;
            end
        end

        // This write runs after the period-start handling. A write on the
        // boundary edge therefore sees the old pending value applied first,
        // and its own value becomes pending for the next boundary.
        if (div_wr) begin
            if (div_in >= MIN_DIV) begin
                wr_ok = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
        if (wr_ok) begin
            pend_d   = div_in;
            pvalid_d = 1'b1;
        end
    end

`ifdef CLK_DIV_PERIOD_CNT_EN
    always_comb begin
        pcnt_d = pcnt_q;
        if (start) begin
            pcnt_d = pcnt_q + 16'd1;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dclk_q   <= 1'b0;
            tick_q   <= 1'b0;
            active_q <= DEF_DIV;
            pend_q   <= '0;
            pvalid_q <= 1'b0;
            err_q    <= 1'b0;
            en_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dclk_q   <= dclk_d;
            tick_q   <= tick_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            pvalid_q <= pvalid_d;
            err_q    <= err_d;
            en_q     <= en;
        end
    end

`ifdef CLK_DIV_PERIOD_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    assign period_cnt = pcnt_q;
`endif

    assign divided_clk = dclk_q;
    assign tick        = tick_q;
    assign div_busy    = pvalid_q;
    assign div_err     = err_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_prog_clk_divider.sv
// -----------------------------------------------------------------------------
// tb_prog_clk_divider
//
// Bench for prog_clk_divider. A reference model describes each period as a
// queue of output bits (ceil(N/2) ones, then floor(N/2) zeros). Every clock
// edge pushes the expected outputs into exp_q. A monitor on the falling edge
// pops each entry and compares it with the DUT. The directed scenarios are
// followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_prog_clk_divider;

    localparam int CNT_W = 16;
    localparam int DEF_N = 10;

`ifdef CLK_DIV_PERIOD_CNT_EN
    localparam int EW = 22;
`else
    localparam int EW = 6;
`endif

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_LOW  = 2'd2;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             div_wr;
    logic [CNT_W-1:0] div_in;
    logic             divided_clk;
    logic             tick;
    logic             div_busy;
    logic             div_err;
    logic [1:0]       state_dbg;
`ifdef CLK_DIV_PERIOD_CNT_EN
    logic [15:0]      period_cnt;
`endif

    always #5 clk = ~clk;

    prog_clk_divider #(
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(DEF_N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .div_wr     (div_wr),
        .div_in     (div_in),
        .divided_clk(divided_clk),
        .tick       (tick),
        .div_busy   (div_busy),
        .div_err    (div_err),
        .state_dbg  (state_dbg)
`ifdef CLK_DIV_PERIOD_CNT_EN
        ,
        .period_cnt (period_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    // ---------------- reference model + scoreboard queue ----------------
    logic [EW-1:0] exp_q[$];

    bit          wave_q[$];
    int unsigned m_active;
    int unsigned m_pend;
    bit          m_pvalid;
    bit          m_running;
    bit          m_en_prev;
    logic [15:0] m_pcnt;

    task automatic model_reset();
        wave_q.delete();
        m_active  = DEF_N;
        m_pend    = 0;
        m_pvalid  = 0;
        m_running = 0;
        m_en_prev = 0;
        m_pcnt    = 16'd0;
    endtask

    task automatic model_step();
        bit            d;
        bit            t;
        bit            e;
        logic [1:0]    st;
        logic [EW-1:0] v;
        int unsigned   hi;
        t = 0;
        if (wave_q.size() != 0) begin
            d = wave_q.pop_front();
        end else if ((m_running && en) || (!m_running && m_en_prev)) begin
            if (m_pvalid) begin
                m_active = m_pend;
                m_pvalid = 0;
            end
            hi = m_active - m_active / 2;
            for (int i = 0; i < int'(m_active); i++) wave_q.push_back(i < int'(hi));
            d         = wave_q.pop_front();
            t         = 1;
            m_running = 1;
            m_pcnt    = m_pcnt + 16'd1;
        end else begin
            d         = 0;
            m_running = 0;
        end
        e = div_wr && (div_in < 2);
        if (div_wr && div_in >= 2) begin
            m_pend   = div_in;
            m_pvalid = 1;
        end
        m_en_prev = en;
        st = !m_running ? S_IDLE : (d ? S_HIGH : S_LOW);
`ifdef CLK_DIV_PERIOD_CNT_EN
        v = {st, d, t, m_pvalid, e, m_pcnt};
`else
        v = {st, d, t, m_pvalid, e};
`endif
        exp_q.push_back(v);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset();
            exp_q.delete();
            exp_q.push_back('0);
        end else begin
            model_step();
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        logic [EW-1:0] got;
        logic [EW-1:0] exp;
`ifdef CLK_DIV_PERIOD_CNT_EN
        got = {state_dbg, divided_clk, tick, div_busy, div_err, period_cnt};
`else
        got = {state_dbg, divided_clk, tick, div_busy, div_err};
`endif
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL queue_empty t=%0t got=%h required=<entry>", $time, got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                bad++;
                $display("FAIL cycle_out t=%0t got {st,clk,tick,busy,err[,cnt]}=%b required=%b",
                         $time, got, exp);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_div(input int unsigned val);
        div_wr = 1'b1;
        div_in = CNT_W'(val);
        step(1);
        div_wr = 1'b0;
    endtask

    task automatic wait_tick(input int budget);
        bit found;
        found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            if (tick === 1'b1) found = 1;
            else step(1);
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL tick_timeout t=%0t got=no_tick required=tick within %0d", $time, budget);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        div_wr = 1'b0;
        div_in = '0;
        step(3);
        rst = 1'b0;
        step(2);

        // Default divisor, continuous run
        en = 1'b1;
        step(40);

        // Switch to 7 while running
        write_div(7);
        step(30);

        // Rejected writes
        write_div(1);
        write_div(0);
        step(20);

        // Back to 10, then drop en two cycles into HIGH
        write_div(10);
        wait_tick(40);
        step(2);
        en = 1'b0;
        step(30);

        // Divisor 4, then asynchronous reset in the LOW phase
        en = 1'b1;
        write_div(4);
        wait_tick(40);
        step(2);
        #1;
        rst = 1'b1;
        #1;
        total++;
        if ({divided_clk, tick, div_busy, div_err} !== 4'b0000) begin
            bad++;
            $display("FAIL async_reset got=%b required=0000",
                     {divided_clk, tick, div_busy, div_err});
        end
        step(3);
        rst = 1'b0;
        step(30);

        // N=2, then back-to-back writes 3 and 6
        write_div(2);
        wait_tick(40);
        step(7);
        write_div(3);
        write_div(6);
        step(30);

        // Randomized run
        for (int i = 0; i < 400; i++) begin
            en     = ($urandom_range(0, 9) != 0);
            div_wr = ($urandom_range(0, 7) == 0);
            div_in = CNT_W'($urandom_range(0, 12));
            step(1);
        end
        div_wr = 1'b0;
        en     = 1'b0;
        step(30);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
